// File: rtl/decode_stage_param_if.sv
// Port bundle of the decode stage: D-stage inputs, W-stage write port,
// E-stage control, and the registered D->E outputs.
interface decode_stage_param_if #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int CTRL_W = 8
);
   localparam int AW = $clog2(NREGS);

   // D-stage instruction and operands
   logic [31:0]       InstrD;
   logic [XLEN-1:0]   PCD;
   logic [XLEN-1:0]   PCPlus4D;
   logic              ValidD;
   logic [CTRL_W-1:0] CtrlD;
   logic [XLEN-1:0]   ImmExtD;
   logic              UsesRs1D;
   logic              UsesRs2D;

   // W-stage write port
   logic              RegWriteW;
   logic [AW-1:0]     RDW;
   logic [XLEN-1:0]   ResultW;

   // E-stage control from later stages
   logic              stallE;
   logic              flushE;

   // D-stage results
   logic [AW-1:0]     RS1D;
   logic [AW-1:0]     RS2D;
   logic              StallD;
   logic              IllegalRegD;

   // D->E pipeline register
   logic [AW-1:0]     RS1E;
   logic [AW-1:0]     RS2E;
   logic [AW-1:0]     RDE;
   logic [XLEN-1:0]   RD1E;
   logic [XLEN-1:0]   RD2E;
   logic [XLEN-1:0]   ImmExtE;
   logic [XLEN-1:0]   PCE;
   logic [XLEN-1:0]   PCPlus4E;
   logic [CTRL_W-1:0] CtrlE;
   logic              ValidE;

   // Upstream side: drives D/W/E-control, observes the stage results
   modport master (
      output InstrD, PCD, PCPlus4D, ValidD, CtrlD, ImmExtD, UsesRs1D, UsesRs2D,
      output RegWriteW, RDW, ResultW, stallE, flushE,
      input  RS1D, RS2D, StallD, IllegalRegD,
      input  RS1E, RS2E, RDE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, CtrlE, ValidE
   );

   // Decode-stage side
   modport slave (
      input  InstrD, PCD, PCPlus4D, ValidD, CtrlD, ImmExtD, UsesRs1D, UsesRs2D,
      input  RegWriteW, RDW, ResultW, stallE, flushE,
      output RS1D, RS2D, StallD, IllegalRegD,
      output RS1E, RS2E, RDE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, CtrlE, ValidE
   );
endinterface

// File: rtl/decode_stage_param.sv
// Decode stage of the pipelined RISC-V core: architectural register file with
// optional same-cycle write-through, load-use hazard detection, RV32E index
// check, and the D->E pipeline register with stall and flush.
module decode_stage_param #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int CTRL_W   = 8,
   parameter int LOAD_BIT = 0,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input logic                 clk,
   input logic                 rst,
   decode_stage_param_if.slave bus
);
   localparam int AW = $clog2(NREGS);

   // Everything the E stage needs from this instruction
   typedef struct packed {
      logic              valid;
      logic [CTRL_W-1:0] ctrl;
      logic [AW-1:0]     rs1;
      logic [AW-1:0]     rs2;
      logic [AW-1:0]     rd;
      logic [XLEN-1:0]   rd1;
      logic [XLEN-1:0]   rd2;
      logic [XLEN-1:0]   imm;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   pc_plus4;
   } e_regs_t;

   logic [XLEN-1:0] rf_q [NREGS];
   logic [XLEN-1:0] rf_d [NREGS];
   e_regs_t         e_q;
   e_regs_t         e_d;

   logic [AW-1:0]   rs1_idx;
   logic [AW-1:0]   rs2_idx;
   logic [XLEN-1:0] rd1_val;
   logic [XLEN-1:0] rd2_val;
   logic            load_use;
   logic            unused_instr;

   assign rs1_idx = bus.InstrD[15 +: AW];
   assign rs2_idx = bus.InstrD[20 +: AW];

   // Only some instruction bits are decoded here; the rest belong to other stages.
   assign unused_instr = ^bus.InstrD;

   // Asynchronous register read, with W-stage forwarding and the hardwired-zero rule
   // NOTE: every signal written in an always_comb gets a value on entry so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      rd1_val = rf_q[rs1_idx];
      rd2_val = rf_q[rs2_idx];
      if (BYPASS != 0 && bus.RegWriteW) begin
         if (rs1_idx == bus.RDW) rd1_val = bus.ResultW;
         if (rs2_idx == bus.RDW) rd2_val = bus.ResultW;
      end
      if (ZERO_REG != 0) begin
         if (rs1_idx == '0) rd1_val = '0;
         if (rs2_idx == '0) rd2_val = '0;
      end
   end

   // Register-file write port; x0 ignores writes when it is hardwired
   always_comb begin
      rf_d = rf_q;
      if (bus.RegWriteW && (ZERO_REG == 0 || bus.RDW != '0)) begin
         rf_d[bus.RDW] = bus.ResultW;
      end
   end

   // Register-file storage, cleared while reset is held
   // NOTE: the architectural state must read 0 after reset, so the file is built from resettable flops rather than an uninitialised RAM.
   // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      end else begin
         rf_q <= rf_d;
      end
   end

   // A load in E whose destination is read by the D instruction must wait one cycle
   assign load_use = e_q.valid & e_q.ctrl[LOAD_BIT] & (e_q.rd != '0) &
                     ((bus.UsesRs1D & (rs1_idx == e_q.rd)) |
                      (bus.UsesRs2D & (rs2_idx == e_q.rd)));

   // A flush squashes the E slot, so D need not hold even if E was stalled
   assign bus.StallD = rst & ~bus.flushE & (bus.stallE | load_use);

   // RV32E only has x0..x15; the trap itself is raised further down the pipe
   assign bus.IllegalRegD = (NREGS == 16) ?
      (bus.ValidD & (bus.InstrD[19] | bus.InstrD[24] | bus.InstrD[11])) : 1'b0;

   assign bus.RS1D = rs1_idx;
   assign bus.RS2D = rs2_idx;

   // Next E contents: flush, then stall, then load-use bubble, then capture
   always_comb begin
      e_d = e_q;
      if (bus.flushE) begin
         e_d = '0;
      end else if (bus.stallE) begin
         e_d = e_q;
      end else if (load_use) begin
         e_d = '0;
      end else begin
         e_d.valid    = bus.ValidD;
         e_d.ctrl     = bus.ValidD ? bus.CtrlD : '0;
         e_d.rs1      = rs1_idx;
         e_d.rs2      = rs2_idx;
         e_d.rd       = bus.InstrD[7 +: AW];
         e_d.rd1      = rd1_val;
         e_d.rd2      = rd2_val;
         e_d.imm      = bus.ImmExtD;
         e_d.pc       = bus.PCD;
         e_d.pc_plus4 = bus.PCPlus4D;
      end
   end

   // D->E pipeline register; reset overrides stall and flush
   always_ff @(posedge clk) begin
      if (!rst) begin
         e_q <= '0;
      end else begin
         e_q <= e_d;
      end
   end

   assign bus.ValidE   = e_q.valid;
   assign bus.CtrlE    = e_q.ctrl;
   assign bus.RS1E     = e_q.rs1;
   assign bus.RS2E     = e_q.rs2;
   assign bus.RDE      = e_q.rd;
   assign bus.RD1E     = e_q.rd1;
   assign bus.RD2E     = e_q.rd2;
   assign bus.ImmExtE  = e_q.imm;
   assign bus.PCE      = e_q.pc;
   assign bus.PCPlus4E = e_q.pc_plus4;
endmodule

// File: tb/tb_decode_stage_param.sv
// Testbench for decode_stage_param: three configurations share one stimulus
// stream, each compared against its own behavioural reference model.
//   u0: XLEN=32 NREGS=32 ZERO_REG=1 BYPASS=1 LOAD_BIT=0
//   u1: XLEN=64 NREGS=16 ZERO_REG=1 BYPASS=0 LOAD_BIT=0
//   u2: XLEN=32 NREGS=32 ZERO_REG=0 BYPASS=1 LOAD_BIT=3
module tb_decode_stage_param;
   localparam int NU = 3;

   function automatic int cfg_xlen(input int i);   return (i == 1) ? 64 : 32; endfunction
   function automatic int cfg_nregs(input int i);  return (i == 1) ? 16 : 32; endfunction
   function automatic int cfg_zero(input int i);   return (i == 2) ? 0 : 1;   endfunction
   function automatic int cfg_bypass(input int i); return (i == 1) ? 0 : 1;   endfunction
   function automatic int cfg_load(input int i);   return (i == 2) ? 3 : 0;   endfunction

   // DUT outputs, zero-extended to the widest configuration
   typedef struct packed {
      logic [4:0]  rs1d;
      logic [4:0]  rs2d;
      logic        stall;
      logic        illegal;
      logic [4:0]  rs1e;
      logic [4:0]  rs2e;
      logic [4:0]  rde;
      logic [63:0] rd1e;
      logic [63:0] rd2e;
      logic [63:0] imme;
      logic [63:0] pce;
      logic [63:0] pc4e;
      logic [7:0]  ctrle;
      logic        valide;
   } obs_t;

   // Reference view of the E slot
   typedef struct {
      logic        valid;
      logic [7:0]  ctrl;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [63:0] rd1;
      logic [63:0] rd2;
      logic [63:0] imm;
      logic [63:0] pc;
      logic [63:0] pc4;
   } ref_e_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic [63:0] pcd, pc4d, immd, resultw;
   logic        validd, use1, use2, regw, stalle, flushe;
   logic [7:0]  ctrld;
   logic [4:0]  rdw;

   obs_t        obs [NU];
   ref_e_t      ref_e [NU];
   logic [63:0] ref_rf [NU][32];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NU; g++) begin : g_unit
      localparam int XL = cfg_xlen(g);
      localparam int NR = cfg_nregs(g);
      localparam int AW = $clog2(NR);

      decode_stage_param_if #(.XLEN(XL), .NREGS(NR), .CTRL_W(8)) bus ();

      assign bus.InstrD    = instr;
      assign bus.PCD       = pcd[XL-1:0];
      assign bus.PCPlus4D  = pc4d[XL-1:0];
      assign bus.ValidD    = validd;
      assign bus.CtrlD     = ctrld;
      assign bus.ImmExtD   = immd[XL-1:0];
      assign bus.UsesRs1D  = use1;
      assign bus.UsesRs2D  = use2;
      assign bus.RegWriteW = regw;
      assign bus.RDW       = rdw[AW-1:0];
      assign bus.ResultW   = resultw[XL-1:0];
      assign bus.stallE    = stalle;
      assign bus.flushE    = flushe;

      decode_stage_param #(
         .XLEN(XL), .NREGS(NR), .CTRL_W(8), .LOAD_BIT(cfg_load(g)),
         .ZERO_REG(cfg_zero(g)), .BYPASS(cfg_bypass(g))
      ) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );

      assign obs[g] = '{rs1d: 5'(bus.RS1D), rs2d: 5'(bus.RS2D), stall: bus.StallD,
                        illegal: bus.IllegalRegD, rs1e: 5'(bus.RS1E), rs2e: 5'(bus.RS2E),
                        rde: 5'(bus.RDE), rd1e: 64'(bus.RD1E), rd2e: 64'(bus.RD2E),
                        imme: 64'(bus.ImmExtE), pce: 64'(bus.PCE), pc4e: 64'(bus.PCPlus4E),
                        ctrle: bus.CtrlE, valide: bus.ValidE};
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic string tg(input int i, input string s);
      return $sformatf("u%0d.%s", i, s);
   endfunction

   function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
   endfunction

   function automatic ref_e_t bubble();
      ref_e_t e;
      e.valid = 1'b0; e.ctrl = '0; e.rs1 = '0; e.rs2 = '0; e.rd = '0;
      e.rd1 = '0; e.rd2 = '0; e.imm = '0; e.pc = '0; e.pc4 = '0;
      return e;
   endfunction

   // Architectural read as seen from D: x0 rule, then optional write-through, then storage
   function automatic logic [63:0] ref_read(input int i, input logic [4:0] idx,
                                            input logic [4:0] wi, input logic [63:0] wd);
      if (cfg_zero(i) != 0 && idx == 5'd0) return 64'd0;
      if (cfg_bypass(i) != 0 && regw && idx == wi) return wd;
      return ref_rf[i][idx];
   endfunction

   // Check D-side outputs against current inputs, then advance the model by one edge
   task automatic ref_step(input int i);
      logic [4:0]  am, rs1, rs2, rd, wi;
      logic [63:0] xm, wd;
      logic        lu, exp_stall, exp_ill;
      am  = (cfg_nregs(i) == 16) ? 5'h0F : 5'h1F;
      xm  = (cfg_xlen(i) == 64) ? '1 : 64'h0000_0000_FFFF_FFFF;
      rs1 = instr[19:15] & am;
      rs2 = instr[24:20] & am;
      rd  = instr[11:7] & am;
      wi  = rdw & am;
      wd  = resultw & xm;
      lu  = ref_e[i].valid && ref_e[i].ctrl[cfg_load(i)] && ref_e[i].rd != 5'd0 &&
            ((use1 && rs1 == ref_e[i].rd) || (use2 && rs2 == ref_e[i].rd));
      exp_stall = rst && !flushe && (stalle || lu);
      exp_ill   = validd && cfg_nregs(i) == 16 && (instr[19] || instr[24] || instr[11]);
      check(tg(i, "rs1d"),    64'(obs[i].rs1d),    64'(rs1));
      check(tg(i, "rs2d"),    64'(obs[i].rs2d),    64'(rs2));
      check(tg(i, "stall_d"), 64'(obs[i].stall),   64'(exp_stall));
      check(tg(i, "illegal"), 64'(obs[i].illegal), 64'(exp_ill));
      if (!rst) begin
         ref_e[i] = bubble();
         for (int r = 0; r < 32; r++) ref_rf[i][r] = 64'd0;
      end else begin
         if (flushe) begin
            ref_e[i] = bubble();
         end else if (stalle) begin
            ref_e[i] = ref_e[i];
         end else if (lu) begin
            ref_e[i] = bubble();
         end else begin
            ref_e[i].valid = validd;
            ref_e[i].ctrl  = validd ? ctrld : 8'd0;
            ref_e[i].rs1   = rs1;
            ref_e[i].rs2   = rs2;
            ref_e[i].rd    = rd;
            ref_e[i].rd1   = ref_read(i, rs1, wi, wd);
            ref_e[i].rd2   = ref_read(i, rs2, wi, wd);
            ref_e[i].imm   = immd & xm;
            ref_e[i].pc    = pcd & xm;
            ref_e[i].pc4   = pc4d & xm;
         end
         if (regw && !(cfg_zero(i) != 0 && wi == 5'd0)) ref_rf[i][wi] = wd;
      end
   endtask

   task automatic check_e(input int i);
      check(tg(i, "valid_e"), 64'(obs[i].valide), 64'(ref_e[i].valid));
      check(tg(i, "ctrl_e"),  64'(obs[i].ctrle),  64'(ref_e[i].ctrl));
      check(tg(i, "rs1_e"),   64'(obs[i].rs1e),   64'(ref_e[i].rs1));
      check(tg(i, "rs2_e"),   64'(obs[i].rs2e),   64'(ref_e[i].rs2));
      check(tg(i, "rd_e"),    64'(obs[i].rde),    64'(ref_e[i].rd));
      check(tg(i, "rd1_e"),   obs[i].rd1e,        ref_e[i].rd1);
      check(tg(i, "rd2_e"),   obs[i].rd2e,        ref_e[i].rd2);
      check(tg(i, "imm_e"),   obs[i].imme,        ref_e[i].imm);
      check(tg(i, "pc_e"),    obs[i].pce,         ref_e[i].pc);
      check(tg(i, "pc4_e"),   obs[i].pc4e,        ref_e[i].pc4);
   endtask

   // One clock: D-side checks at the falling edge, E-side checks just after the rising edge
   task automatic cycle();
      @(negedge clk);
      for (int i = 0; i < NU; i++) ref_step(i);
      @(posedge clk);
      #1;
      for (int i = 0; i < NU; i++) check_e(i);
   endtask

   function automatic logic [4:0] rnd_reg();
      return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "time limit reached");
   end

   initial begin
      for (int i = 0; i < NU; i++) ref_e[i] = bubble();
      rst = 1'b0; instr = mk(5'd5, 5'd5, 5'd5); pcd = 64'h40; pc4d = 64'h44; immd = 64'd0;
      validd = 1'b1; ctrld = 8'hFF; use1 = 1'b1; use2 = 1'b0; regw = 1'b0; rdw = 5'd0;
      resultw = 64'd0; stalle = 1'b0; flushe = 1'b0;

      // Reset held two cycles with a live instruction in D
      cycle();
      cycle();
      check("rst.valid_e", 64'(obs[0].valide), 64'd0);
      check("rst.ctrl_e",  64'(obs[0].ctrle),  64'd0);
      check("rst.rd1_e",   obs[0].rd1e,        64'd0);
      check("rst.stall_d", 64'(obs[0].stall),  64'd0);

      // x5 reads 0 after reset
      rst = 1'b1; ctrld = 8'h02; instr = mk(5'd1, 5'd5, 5'd0);
      cycle();
      for (int i = 0; i < NU; i++) check(tg(i, "x5_after_rst"), obs[i].rd1e, 64'd0);

      // Same-cycle write of x5 while D reads it
      regw = 1'b1; rdw = 5'd5; resultw = 64'h0000_0000_DEAD_BEEF; instr = mk(5'd2, 5'd5, 5'd0);
      cycle();
      check("byp.u0", obs[0].rd1e, 64'hDEAD_BEEF);
      check("byp.u1", obs[1].rd1e, 64'd0);
      check("byp.u2", obs[2].rd1e, 64'hDEAD_BEEF);
      regw = 1'b0;
      cycle();
      check("byp.u1_late", obs[1].rd1e, 64'hDEAD_BEEF);

      // Write to x0
      regw = 1'b1; rdw = 5'd0; resultw = 64'h1234; instr = mk(5'd3, 5'd0, 5'd0);
      cycle();
      regw = 1'b0;
      cycle();
      check("x0.u0", obs[0].rd1e, 64'd0);
      check("x0.u1", obs[1].rd1e, 64'd0);
      check("x0.u2", obs[2].rd1e, 64'h1234);

      // Load to x7, followed by a dependent add reading rs2=x7
      instr = mk(5'd7, 5'd1, 5'd2); ctrld = 8'h09; use1 = 1'b1; use2 = 1'b1;
      cycle();
      check("lu.load_rd", 64'(obs[0].rde), 64'd7);
      instr = mk(5'd8, 5'd1, 5'd7); ctrld = 8'h02;
      #1;
      for (int i = 0; i < NU; i++) check(tg(i, "lu.stall"), 64'(obs[i].stall), 64'd1);
      cycle();
      check("lu.bubble_valid", 64'(obs[0].valide), 64'd0);
      check("lu.bubble_ctrl",  64'(obs[0].ctrle),  64'd0);
      #1;
      check("lu.stall_released", 64'(obs[0].stall), 64'd0);
      cycle();
      check("lu.add_valid", 64'(obs[0].valide), 64'd1);
      check("lu.add_rd",    64'(obs[0].rde),    64'd8);

      // Same pair without rs2 use: no stall
      instr = mk(5'd7, 5'd1, 5'd2); ctrld = 8'h09; use2 = 1'b0;
      cycle();
      instr = mk(5'd8, 5'd1, 5'd7); ctrld = 8'h02;
      #1;
      check("nolu.stall", 64'(obs[0].stall), 64'd0);
      cycle();
      check("nolu.add_rd", 64'(obs[0].rde), 64'd8);

      // Flush and stall together: flush wins, D not held
      use1 = 1'b0; instr = mk(5'd9, 5'd1, 5'd2); pcd = 64'h100;
      cycle();
      stalle = 1'b1; flushe = 1'b1; pcd = 64'h200;
      #1;
      check("prio.stall_d", 64'(obs[0].stall), 64'd0);
      cycle();
      check("prio.valid_e", 64'(obs[0].valide), 64'd0);

      // Stall alone for three cycles: E holds, D held
      stalle = 1'b0; flushe = 1'b0; pcd = 64'h100;
      cycle();
      stalle = 1'b1; pcd = 64'h300; instr = mk(5'd10, 5'd3, 5'd4);
      for (int k = 0; k < 3; k++) begin
         #1;
         check("hold.stall_d", 64'(obs[0].stall), 64'd1);
         cycle();
         check("hold.pc_e", obs[0].pce, 64'h100);
         check("hold.rd_e", 64'(obs[0].rde), 64'd9);
      end
      stalle = 1'b0;

      // RV32E register range
      instr = mk(5'd17, 5'd0, 5'd0);
      #1;
      check("rv32e.ill_x17", 64'(obs[1].illegal), 64'd1);
      check("rv32i.ill_x17", 64'(obs[0].illegal), 64'd0);
      cycle();
      check("rv32e.rd_x17", 64'(obs[1].rde), 64'h1);
      check("rv32i.rd_x17", 64'(obs[0].rde), 64'd17);
      instr = mk(5'd15, 5'd0, 5'd0);
      #1;
      check("rv32e.ill_x15", 64'(obs[1].illegal), 64'd0);

      // Full 64-bit PC and immediate
      pcd = 64'h8000_0000_0000_0004; immd = 64'hFFFF_FFFF_FFFF_FFF0;
      cycle();
      check("x64.pc_e",  obs[1].pce,  64'h8000_0000_0000_0004);
      check("x64.imm_e", obs[1].imme, 64'hFFFF_FFFF_FFFF_FFF0);
      check("x32.pc_e",  obs[0].pce,  64'h4);
      check("x32.imm_e", obs[0].imme, 64'hFFFF_FFF0);

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         rst     = ($urandom_range(0, 49) != 0);
         instr   = $urandom;
         instr[11:7]  = rnd_reg();
         instr[19:15] = rnd_reg();
         instr[24:20] = rnd_reg();
         pcd     = {$urandom, $urandom};
         pc4d    = {$urandom, $urandom};
         immd    = {$urandom, $urandom};
         validd  = ($urandom_range(0, 4) != 0);
         ctrld   = 8'($urandom);
         use1    = 1'($urandom);
         use2    = 1'($urandom);
         regw    = ($urandom_range(0, 9) < 7);
         rdw     = rnd_reg();
         resultw = {$urandom, $urandom};
         stalle  = ($urandom_range(0, 99) < 15);
         flushe  = ($urandom_range(0, 99) < 10);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/decode_stage_param.md
Name: decode_stage_param

Overview:
- Parametrised next-generation decode stage for the pipelined RISC-V core.
- Contains the architectural register file with optional write-through bypass, load-use hazard detection, and the D->E pipeline register with valid, stall and flush.
- Control decode and immediate generation stay outside this block. The control word arrives as an opaque CTRL_W-bit bundle, and the immediate arrives already extended.
- Supports RV32I (32 registers) and RV32E (16 registers) at any XLEN.

Parameters:
XLEN, 32, datapath width of PC, register and immediate values
NREGS, 32, register count; legal values 16 or 32; AW = log2(NREGS)
CTRL_W, 8, width of the opaque control bundle CtrlD/CtrlE
LOAD_BIT, 0, index into CtrlD that marks a load (ResultSrc = memory)
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes
BYPASS, 1, 1 = a same-cycle W-stage write is forwarded to the D-stage read

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-low
InstrD  in  32  instruction in D
PCD  in  XLEN  PC of D instruction
PCPlus4D  in  XLEN  PC+4 of D instruction
ValidD  in  1  D slot holds a real instruction
CtrlD  in  CTRL_W  decoded control bundle
ImmExtD  in  XLEN  extended immediate
UsesRs1D  in  1  instruction reads rs1
UsesRs2D  in  1  instruction reads rs2
RegWriteW  in  1  writeback enable
RDW  in  AW  writeback register index
ResultW  in  XLEN  writeback data
stallE  in  1  hold the E register (back-pressure from later stages)
flushE  in  1  squash the E register (branch redirect)
RS1D  out  AW  InstrD[15 +: AW]
RS2D  out  AW  InstrD[20 +: AW]
StallD  out  1  hold PC and the F->D register
IllegalRegD  out  1  RV32E register index out of range
RS1E, RS2E, RDE  out  AW  registered register indices
RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  XLEN  registered operands and PCs
CtrlE  out  CTRL_W  registered control bundle
ValidE  out  1  E slot holds a real instruction

Behaviour:
Register file:
- NREGS x XLEN storage; asynchronous read.
- Write occurs at the clock edge when RegWriteW=1 and (ZERO_REG=0 or RDW!=0).
- While rst=0, every entry is cleared to 0 at the clock edge and writes are ignored.
- Read of register 0 with ZERO_REG=1 returns 0.
- With BYPASS=1, a read whose index equals RDW while RegWriteW=1 returns ResultW (same cycle), subject to the register-0 rule.
- With BYPASS=0, a read returns the stored value; a write becomes visible on the next cycle.

Hazard detection:
- loaduse = ValidE & CtrlE[LOAD_BIT] & (RDE!=0) & ((UsesRs1D & RS1D==RDE) | (UsesRs2D & RS2D==RDE)).
- StallD = rst & ~flushE & (stallE | loaduse).

Illegal register check:
- IllegalRegD = ValidD & (NREGS==16) & (InstrD[19] | InstrD[24] | InstrD[11]).
- The instruction still proceeds; the trap is handled elsewhere.

D->E register update at each clock edge, highest priority first:
1. rst=0: all E outputs go to 0 and ValidE=0.
2. flushE=1: bubble. ValidE=0, CtrlE=0, and all data and index fields = 0.
3. stallE=1: all E fields hold their current values.
4. loaduse=1: bubble, same as flushE. D is held by StallD, so the instruction re-issues the next cycle.
5. Otherwise capture:
   - ValidE <= ValidD.
   - CtrlE <= ValidD ? CtrlD : 0.
   - RD1E/RD2E <= register file reads, bypass included.
   - RDE <= InstrD[7 +: AW].
   - All other fields take their D counterparts.

Latency and widths:
- Latency D->E is exactly 1 cycle; there is no internal combinational path from D inputs to E outputs.
- All widths are exact; there is no extension or truncation except the AW slicing of register index fields.

Reset behaviour:
- Reset asserted mid-stall or mid-flush wins at the next edge.
- After reset deasserts, the first captured instruction appears in E on the following edge.

Test Plan:
- Reset: drive rst=0 for 2 cycles with ValidD=1 and CtrlD=8'hFF -> ValidE=0, CtrlE=0, RD1E=0, StallD=0. After release, reading x5 returns 0.
- Bypass: RegWriteW=1, RDW=5, ResultW=32'hDEADBEEF in the same cycle as InstrD with rs1=5 -> next cycle RD1E=32'hDEADBEEF. With BYPASS=0 -> RD1E = old value 0. Write RDW=0 with 32'h1234 -> a later read of x0 gives 0.
- Load-use: a load writing x7 in E (CtrlE[0]=1, RDE=7, ValidE=1) and an add reading rs2=7 in D -> StallD=1 for 1 cycle, then next-edge ValidE=0 and CtrlE=0, then the add is captured. Repeat with UsesRs2D=0 -> no stall.
- Priority: flushE=1 and stallE=1 together -> ValidE=0 and StallD=0. stallE=1 alone for 3 cycles -> all E outputs unchanged and StallD=1.
- RV32E (NREGS=16): InstrD with rd=x17 -> IllegalRegD=1 and RDE=4'h1. With rd=x15 -> IllegalRegD=0.
- XLEN=64: PCD=64'h8000_0000_0000_0004 and ImmExtD=64'hFFFF_FFFF_FFFF_FFF0 -> same values on PCE and ImmExtE after 1 cycle.
